// File: rtl/block_framer_130b.sv
`default_nettype none
// ============================================================================
// block_framer_130b : 128b/130b TX block framer, word FIFO plus bit serializer
// Rev 1.0
// ============================================================================
module block_framer_130b #(
    parameter int DATA_W      = 8,
    parameter int BLOCK_WORDS = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int LSB_FIRST   = 1
) (
    input  logic                             clk_8G,
    input  logic                             rst_8G,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_sob,
    input  logic                             in_os,
    input  logic                             tx_en,
    output logic                             data_out,
    output logic                             data_out_valid,
    output logic                             sob_out,
    output logic                             framing_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                      blk_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_W + 2;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WRD_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [LVL_W-1:0] c_LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] c_LVL_BLOCK = LVL_W'(BLOCK_WORDS);
    localparam logic [BIT_W-1:0] c_BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [WRD_W-1:0] c_WRD_LAST  = WRD_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD} state_t;

    state_t             r_state;
    logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [DATA_W-1:0]  r_shift;
    logic [BIT_W-1:0]   r_bit;
    logic [WRD_W-1:0]   r_word;
    logic               r_blk_os;
    logic               r_data_out;
    logic               r_valid;
    logic               r_sob;
    logic               r_ferr;
    logic [15:0]        r_blk_cnt;

    logic [ENT_W-1:0]   w_head;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_head_sob;
    logic               w_head_os;
    logic               w_push;
    logic               w_pop;
    logic               w_start;
    logic               w_discard;
    logic               w_last_bit;
    logic               w_last_word;
    logic               w_tx_bit;
    logic [DATA_W-1:0]  w_shift_nx;
    logic [1:0]         w_hdr;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[DATA_W-1:0];
    assign w_head_sob  = w_head[DATA_W];
    assign w_head_os   = w_head[DATA_W+1];

    assign in_ready    = (r_level < c_LVL_FULL);
    assign w_push      = in_valid && in_ready;
    // A block may only start once all of its words are buffered.
    assign w_start     = tx_en && (r_level >= c_LVL_BLOCK) && w_head_sob;
    assign w_discard   = (r_level != '0) && !w_head_sob;
    assign w_last_bit  = (r_bit == c_BIT_LAST);
    assign w_last_word = (r_word == c_WRD_LAST);
    assign w_hdr       = r_blk_os ? 2'b01 : 2'b10;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_tx_bit   = r_shift[0];
            assign w_shift_nx = {1'b0, r_shift[DATA_W-1:1]};
        end else begin : g_msb_first
            assign w_tx_bit   = r_shift[DATA_W-1];
            assign w_shift_nx = {r_shift[DATA_W-2:0], 1'b0};
        end
    endgenerate

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:    w_pop = w_discard || w_start;
            S_PAYLOAD: w_pop = w_last_bit && (!w_last_word || w_start);
            default:   w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_8G) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_os, in_sob, in_data};
        end
    end

    always_ff @(posedge clk_8G or negedge rst_8G) begin
        if (!rst_8G) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk_8G or negedge rst_8G) begin
        if (!rst_8G) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit      <= '0;
            r_word     <= '0;
            r_blk_os   <= 1'b0;
            r_data_out <= 1'b0;
            r_valid    <= 1'b0;
            r_sob      <= 1'b0;
            r_ferr     <= 1'b0;
            r_blk_cnt  <= '0;
        end else begin
            r_ferr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_data_out <= 1'b0;
                    r_valid    <= 1'b0;
                    r_sob      <= 1'b0;
                    if (w_discard) begin
                        r_ferr <= 1'b1;
                    end else if (w_start) begin
                        r_blk_os <= w_head_os;
                        r_shift  <= w_head_data;
                        r_bit    <= '0;
                        r_word   <= '0;
                        r_state  <= S_HDR0;
                    end
                end
                S_HDR0: begin
                    r_data_out <= w_hdr[0];
                    r_valid    <= 1'b1;
                    r_sob      <= 1'b1;
                    r_blk_cnt  <= r_blk_cnt + 16'd1;
                    r_state    <= S_HDR1;
                end
                S_HDR1: begin
                    r_data_out <= w_hdr[1];
                    r_sob      <= 1'b0;
                    r_state    <= S_PAYLOAD;
                end
                default: begin
                    r_data_out <= w_tx_bit;
                    r_shift    <= w_shift_nx;
                    r_bit      <= r_bit + BIT_W'(1);
                    if (w_last_bit) begin
                        r_bit <= '0;
                        if (!w_last_word) begin
                            // A start-of-block flag inside a block is reported but its data still goes out.
                            r_word  <= r_word + WRD_W'(1);
                            r_shift <= w_head_data;
                            r_ferr  <= w_head_sob;
                        end else if (w_start) begin
                            r_blk_os <= w_head_os;
                            r_shift  <= w_head_data;
                            r_word   <= '0;
                            r_state  <= S_HDR0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_valid;
    assign sob_out        = r_sob;
    assign framing_err    = r_ferr;
    assign fifo_level     = r_level;
    assign blk_cnt        = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_block_framer_130b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_block_framer_130b : randomized scoreboard bench for block_framer_130b
// Rev 1.0
// ============================================================================
module tb_block_framer_130b;

    localparam int DW   = 8;
    localparam int BW   = 16;
    localparam int BLK  = 2 + DW * BW;
    localparam int DW2  = 16;
    localparam int BW2  = 8;
    localparam int BLK2 = 2 + DW2 * BW2;

    logic clk_8G = 1'b0;
    logic rst_8G = 1'b0;
    always #5 clk_8G = ~clk_8G;

    logic          in_valid = 1'b0, in_sob = 1'b0, in_os = 1'b0, tx_en = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready, data_out, data_out_valid, sob_out, framing_err;
    logic [5:0]    fifo_level;
    logic [15:0]   blk_cnt;

    logic           b_valid_in = 1'b0, b_sob_in = 1'b0, b_tx_en = 1'b0;
    logic [DW2-1:0] b_data = '0;
    logic           b_ready, b_dout, b_valid, b_sob, b_ferr;
    logic [5:0]     b_level;
    logic [15:0]    b_blk_cnt;

    block_framer_130b #(.DATA_W(DW), .BLOCK_WORDS(BW), .FIFO_DEPTH(32), .LSB_FIRST(1)) u_dut (
        .clk_8G(clk_8G), .rst_8G(rst_8G), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sob(in_sob), .in_os(in_os), .tx_en(tx_en),
        .data_out(data_out), .data_out_valid(data_out_valid), .sob_out(sob_out),
        .framing_err(framing_err), .fifo_level(fifo_level), .blk_cnt(blk_cnt)
    );

    block_framer_130b #(.DATA_W(DW2), .BLOCK_WORDS(BW2), .FIFO_DEPTH(32), .LSB_FIRST(0)) u_dut2 (
        .clk_8G(clk_8G), .rst_8G(rst_8G), .in_valid(b_valid_in), .in_ready(b_ready),
        .in_data(b_data), .in_sob(b_sob_in), .in_os(1'b0), .tx_en(b_tx_en),
        .data_out(b_dout), .data_out_valid(b_valid), .sob_out(b_sob),
        .framing_err(b_ferr), .fifo_level(b_level), .blk_cnt(b_blk_cnt)
    );

    int n_pass = 0, n_total = 0;
    int cyc = 0;
    always @(posedge clk_8G) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: words not yet assigned to a block, and the serial stream they will produce.
    logic [DW+1:0] pend[$];
    logic [1:0]    exp_q[$];
    logic [1:0]    exp2_q[$];
    int exp_ferr = 0, exp_blocks = 0;

    task automatic model_push(input logic [DW+1:0] w);
        logic [DW+1:0] cur;
        logic          os;
        pend.push_back(w);
        while (pend.size() != 0) begin
            if (!pend[0][DW]) begin
                cur = pend.pop_front();
                exp_ferr++;
                continue;
            end
            if (pend.size() < BW) break;
            os = pend[0][DW+1];
            exp_q.push_back({1'b1, os});
            exp_q.push_back({1'b0, ~os});
            for (int wi = 0; wi < BW; wi++) begin
                cur = pend.pop_front();
                if (wi > 0 && cur[DW]) exp_ferr++;
                for (int b = 0; b < DW; b++) exp_q.push_back({1'b0, cur[b]});
            end
            exp_blocks++;
        end
    endtask

    int   last_acc_cyc = 0, n_acc = 0;
    logic last_acc = 1'b0;

    task automatic push(input logic [DW-1:0] d, input logic sob, input logic os);
        in_valid = 1'b1; in_data = d; in_sob = sob; in_os = os;
        @(negedge clk_8G);
        last_acc = in_ready;
        @(posedge clk_8G); #1;
        in_valid = 1'b0;
        if (last_acc) begin
            model_push({os, sob, d});
            last_acc_cyc = cyc;
            n_acc++;
        end
    endtask

    task automatic push2(input logic [DW2-1:0] d, input logic sob);
        logic acc;
        b_valid_in = 1'b1; b_data = d; b_sob_in = sob;
        @(negedge clk_8G);
        acc = b_ready;
        @(posedge clk_8G); #1;
        b_valid_in = 1'b0;
        if (acc) begin
            if (sob) begin
                exp2_q.push_back(2'b10);
                exp2_q.push_back(2'b01);
            end
            for (int b = DW2 - 1; b >= 0; b--) exp2_q.push_back({1'b0, d[b]});
        end else begin
            n_total++;
            $display("FAIL dut2_push_rejected: in_ready 0, expected 1");
        end
    endtask

    int run_len = 0, vcnt = 0, ferr_seen = 0, sob_cyc = 0, prev_sob_cyc = 0;

    always @(negedge clk_8G) begin : mon1
        logic [1:0] e;
        if (!rst_8G) begin
            run_len = 0;
        end else begin
            if (framing_err) ferr_seen++;
            if (data_out_valid) begin
                vcnt++;
                run_len++;
                if (sob_out) begin
                    prev_sob_cyc = sob_cyc;
                    sob_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_bit: got data_out=%0d sob_out=%0d, no bit expected", data_out, sob_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("sob/bit", {sob_out, data_out}, e);
                end
            end else begin
                if (run_len != 0) begin
                    chk("run_len_mod_block", run_len % BLK, 0);
                    run_len = 0;
                end
                chk("idle_outputs", {sob_out, data_out}, 0);
            end
        end
    end

    int run2 = 0;
    always @(negedge clk_8G) begin : mon2
        logic [1:0] e;
        if (!rst_8G) begin
            run2 = 0;
        end else if (b_valid) begin
            run2++;
            if (exp2_q.size() == 0) begin
                n_total++;
                $display("FAIL dut2_extra_bit: got data_out=%0d, no bit expected", b_dout);
            end else begin
                e = exp2_q.pop_front();
                chk("dut2_sob/bit", {b_sob, b_dout}, e);
            end
        end else if (run2 != 0) begin
            chk("dut2_block_len", run2, BLK2);
            run2 = 0;
        end
    end

    task automatic drain();
        int k = 0;
        tx_en = 1'b1;
        while ((exp_q.size() != 0 || data_out_valid) && k < 2000) begin
            @(negedge clk_8G);
            k++;
        end
        if (k >= 2000) begin
            n_total++;
            $display("FAIL drain_timeout: %0d bits outstanding, expected 0", exp_q.size());
        end
        repeat (4) @(negedge clk_8G);
        chk("blk_cnt", blk_cnt, exp_blocks);
        chk("framing_err_count", ferr_seen, exp_ferr);
        chk("fifo_level", fifo_level, pend.size());
        @(posedge clk_8G); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int vbase;
        int pos;
        logic s;
        #3;
        chk("rst_outputs", {data_out_valid, sob_out, data_out, framing_err}, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk_8G);
        #1 rst_8G = 1'b1;
        @(posedge clk_8G); #1;

        // Single data block 0x00..0x0F with header latency check.
        tx_en = 1'b1;
        for (int i = 0; i < BW; i++) push(DW'(i), i == 0, 1'b0);
        drain();
        chk("hdr_latency", sob_cyc, last_acc_cyc + 2);

        // Ordered-set block of 0xAA.
        for (int i = 0; i < BW; i++) push(8'hAA, i == 0, 1'b1);
        drain();

        // Back-to-back data + ordered-set blocks queued before enabling.
        tx_en = 1'b0;
        for (int i = 0; i < 2 * BW; i++) push(DW'($urandom), (i % BW) == 0, i >= BW);
        drain();
        chk("b2b_sob_spacing", sob_cyc - prev_sob_cyc, BLK);

        // Stray word is discarded; 15 words give no output; 16th triggers.
        vbase = vcnt;
        push(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < BW - 1; i++) push(DW'($urandom), i == 0, 1'b0);
        repeat (20) @(negedge clk_8G);
        chk("gate_partial_no_output", vcnt - vbase, 0);
        chk("stray_framing_err", ferr_seen, exp_ferr);
        chk("gate_partial_level", fifo_level, BW - 1);
        @(posedge clk_8G); #1;
        push(DW'($urandom), 1'b0, 1'b0);
        drain();

        // Full block held off by tx_en=0.
        tx_en = 1'b0;
        for (int i = 0; i < BW; i++) push(DW'($urandom), i == 0, 1'b0);
        vbase = vcnt;
        repeat (30) @(negedge clk_8G);
        chk("tx_en_hold_no_output", vcnt - vbase, 0);
        chk("tx_en_hold_level", fifo_level, BW);
        @(posedge clk_8G); #1;
        drain();

        // Backpressure at full FIFO.
        tx_en = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 40; i++) push(DW'(i), (n_acc % BW) == 0, 1'b0);
        chk("bp_accepted", n_acc, 32);
        chk("bp_level", fifo_level, 32);
        chk("bp_in_ready_low", in_ready, 0);
        tx_en = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk_8G); k++; end
        chk("bp_in_ready_back", in_ready, 1);
        @(posedge clk_8G); #1;
        drain();

        // Reset at payload bit 40.
        for (int i = 0; i < BW; i++) push(DW'($urandom), i == 0, 1'b0);
        k = 0;
        while (run_len != 42 && k < 500) begin @(negedge clk_8G); k++; end
        chk("reach_payload_bit40", run_len, 42);
        #1 rst_8G = 1'b0;
        #1;
        chk("midrst_outputs", {data_out_valid, sob_out, data_out, framing_err}, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_blk_cnt", blk_cnt, 0);
        chk("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        pend.delete();
        exp_blocks = 0;
        repeat (2) @(posedge clk_8G);
        #1 rst_8G = 1'b1;
        @(posedge clk_8G); #1;
        for (int i = 0; i < BW; i++) push(DW'($urandom), i == 0, 1'b0);
        drain();

        // Randomized traffic with occasional framing faults and tx_en toggles.
        pos = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) tx_en = ~tx_en;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_8G); #1;
            end else begin
                s = (pos == 0) ^ ($urandom_range(0, 29) == 0);
                push(DW'($urandom), s, 1'($urandom));
                if (last_acc) pos = (pos + 1) % BW;
            end
        end
        drain();

        // MSB-first, 16-bit, 8-word instance.
        b_tx_en = 1'b1;
        push2(16'h8001, 1'b1);
        for (int i = 1; i < BW2; i++) push2(DW2'($urandom), 1'b0);
        k = 0;
        while ((exp2_q.size() != 0 || b_valid) && k < 400) begin @(negedge clk_8G); k++; end
        chk("dut2_drained", exp2_q.size(), 0);
        repeat (3) @(negedge clk_8G);
        chk("dut2_blk_cnt", b_blk_cnt, 1);
        chk("dut2_level", b_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
